// File: rtl/axis_len_pkg.sv
// Shared definitions for the frame length meter.
//   popcount      : counts set bits of a keep vector (zero-extend narrower inputs)
//   frame_state_t : frame tracking FSM states
//   FLG_*         : bit positions inside the 4-bit status flag field
package axis_len_pkg;

  // Widest keep vector popcount accepts (1024-bit data bus).
  localparam int unsigned POPCNT_MAX_W = 128;
  localparam int unsigned POPCNT_OUT_W = 8;

  localparam int unsigned FLG_RUNT = 0;
  localparam int unsigned FLG_OVER = 1;
  localparam int unsigned FLG_ERR  = 2;
  localparam int unsigned FLG_SAT  = 3;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } frame_state_t;

  function automatic logic [POPCNT_OUT_W-1:0] popcount(input logic [POPCNT_MAX_W-1:0] v);
    logic [POPCNT_OUT_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(POPCNT_MAX_W); i++) begin
      n = n + POPCNT_OUT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/axis_skid_reg_an.sv
// One-deep registered skid buffer for an AXI-Stream beat.
//   in_*  : upstream beat (tdata/tkeep/tuser/tlast), tvalid/tready handshake
//   out_* : downstream beat, registered, 1-cycle latency, full throughput
// in_tready is low during reset, high from the first edge after release, and
// low whenever the skid register holds a beat.
module axis_skid_reg_an #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_tdata,
  input  logic [KEEP_WIDTH-1:0] in_tkeep,
  input  logic                  in_tlast,
  input  logic [USER_WIDTH-1:0] in_tuser,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  output logic [DATA_WIDTH-1:0] out_tdata,
  output logic [KEEP_WIDTH-1:0] out_tkeep,
  output logic                  out_tlast,
  output logic [USER_WIDTH-1:0] out_tuser,
  output logic                  out_tvalid,
  input  logic                  out_tready
);

  localparam int unsigned PW = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;

  logic [PW-1:0] in_pay;
  logic [PW-1:0] prim_reg;
  logic [PW-1:0] skid_reg;
  logic          prim_valid_reg;
  logic          skid_valid_reg;
  logic          live_reg;
  logic          in_hs;

  assign in_pay    = {in_tdata, in_tkeep, in_tuser, in_tlast};
  assign in_tready = live_reg & ~skid_valid_reg;
  assign in_hs     = in_tvalid & in_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prim_reg       <= '0;
      skid_reg       <= '0;
      prim_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      live_reg       <= 1'b0;
    end else begin
      live_reg <= 1'b1;
      if (skid_valid_reg) begin
        // Input is blocked; primary stays valid, refilled from the skid slot.
        if (out_tready) begin
          prim_reg       <= skid_reg;
          skid_valid_reg <= 1'b0;
        end
      end else if (in_hs) begin
        if (!prim_valid_reg || out_tready) begin
          prim_reg       <= in_pay;
          prim_valid_reg <= 1'b1;
        end else begin
          skid_reg       <= in_pay;
          skid_valid_reg <= 1'b1;
        end
      end else if (out_tready) begin
        prim_valid_reg <= 1'b0;
      end
    end
  end

  assign {out_tdata, out_tkeep, out_tuser, out_tlast} = prim_reg;
  assign out_tvalid = prim_valid_reg;

endmodule

// File: rtl/axis_frame_len_meter.sv
// Frame length meter: passes an AXI-Stream through a registered skid stage and
// reports one status word per frame on the m_len channel.
//   s_axis_* : input stream (tuser[0] = error)
//   m_axis_* : output stream, unmodified, 1-cycle latency
//   m_len_*  : per-frame byte length and flags {sat, err, oversize, runt}
module axis_frame_len_meter
  import axis_len_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned MIN_LEN    = 60,
  parameter int unsigned MAX_LEN    = 1518
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic [LEN_WIDTH-1:0]  m_len_tdata,
  output logic [3:0]            m_len_tflags,
  output logic                  m_len_tvalid,
  input  logic                  m_len_tready
);

  frame_state_t         state_reg, state_next;
  logic [LEN_WIDTH-1:0] acc_reg;
  logic                 err_reg;
  logic                 sat_reg;
  logic [LEN_WIDTH-1:0] len_reg;
  logic [3:0]           flags_reg;
  logic                 len_valid_reg;

  logic                 skid_ready;
  logic                 tlast_stall;
  logic                 in_hs;
  logic                 push;
  logic [LEN_WIDTH:0]   beat_bytes;
  logic [LEN_WIDTH:0]   sum;
  logic [LEN_WIDTH-1:0] new_len;
  logic                 new_err;
  logic                 new_sat;
  logic [3:0]           new_flags;

  // Only a frame-ending beat needs a free status slot; other beats flow freely.
  assign tlast_stall   = s_axis_tvalid & s_axis_tlast & len_valid_reg & ~m_len_tready;
  assign s_axis_tready = skid_ready & ~tlast_stall;
  assign in_hs         = s_axis_tvalid & s_axis_tready;
  assign push          = in_hs & s_axis_tlast;

  axis_skid_reg_an #(
    .DATA_WIDTH(DATA_WIDTH),
    .KEEP_WIDTH(KEEP_WIDTH),
    .USER_WIDTH(USER_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_tdata  (s_axis_tdata),
    .in_tkeep  (s_axis_tkeep),
    .in_tlast  (s_axis_tlast),
    .in_tuser  (s_axis_tuser),
    .in_tvalid (s_axis_tvalid & ~tlast_stall),
    .in_tready (skid_ready),
    .out_tdata (m_axis_tdata),
    .out_tkeep (m_axis_tkeep),
    .out_tlast (m_axis_tlast),
    .out_tuser (m_axis_tuser),
    .out_tvalid(m_axis_tvalid),
    .out_tready(m_axis_tready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // In IDLE the accumulator contents are stale, so the first beat starts from 0.
  always_comb begin
    state_next = state_reg;
    beat_bytes = (LEN_WIDTH + 1)'(popcount(POPCNT_MAX_W'(s_axis_tkeep)));
    sum        = beat_bytes;
    new_err    = s_axis_tuser[0];
    new_sat    = 1'b0;
    if (state_reg == IN_FRAME) begin
      sum     = {1'b0, acc_reg} + beat_bytes;
      new_err = err_reg | s_axis_tuser[0];
      new_sat = sat_reg;
    end
    new_sat = new_sat | sum[LEN_WIDTH];
    new_len = sum[LEN_WIDTH] ? {LEN_WIDTH{1'b1}} : sum[LEN_WIDTH-1:0];
    new_flags           = '0;
    new_flags[FLG_RUNT] = (32'(new_len) < MIN_LEN);
    new_flags[FLG_OVER] = (32'(new_len) > MAX_LEN);
    new_flags[FLG_ERR]  = new_err;
    new_flags[FLG_SAT]  = new_sat;
    if (in_hs) begin
      state_next = s_axis_tlast ? IDLE : IN_FRAME;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
      err_reg <= 1'b0;
      sat_reg <= 1'b0;
    end else if (in_hs && !s_axis_tlast) begin
      acc_reg <= new_len;
      err_reg <= new_err;
      sat_reg <= new_sat;
    end
  end

  // Single status slot; a push in the same cycle as a pop simply overwrites.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_reg       <= '0;
      flags_reg     <= '0;
      len_valid_reg <= 1'b0;
    end else if (push) begin
      len_reg       <= new_len;
      flags_reg     <= new_flags;
      len_valid_reg <= 1'b1;
    end else if (m_len_tready) begin
      len_valid_reg <= 1'b0;
    end
  end

  assign m_len_tdata  = len_reg;
  assign m_len_tflags = flags_reg;
  assign m_len_tvalid = len_valid_reg;

endmodule

// File: tb/tb_axis_frame_len_meter.sv
module tb_axis_frame_len_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] s_tdata = '0;
  logic [7:0]  s_tkeep = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic [0:0]  s_tuser = '0;
  logic        en1 = 1'b1;
  logic        en2 = 1'b0;
  logic        m_tready;
  logic        len_tready1 = 1'b1;
  logic        len_tready2 = 1'b1;
  bit          bp_en = 1'b0;
  bit          lat_chk = 1'b0;

  // DUT1 (LEN_WIDTH=16)
  logic        s_tready1;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid, m_tlast;
  logic [0:0]  m_tuser;
  logic [15:0] len1;
  logic [3:0]  flags1;
  logic        lvalid1;

  // DUT2 (LEN_WIDTH=8)
  logic        s_tready2;
  logic [63:0] m2_tdata;
  logic [7:0]  m2_tkeep;
  logic        m2_tvalid, m2_tlast;
  logic [0:0]  m2_tuser;
  logic [7:0]  len2;
  logic [3:0]  flags2;
  logic        lvalid2;

  axis_frame_len_meter #(.DATA_WIDTH(64), .USER_WIDTH(1), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid & en1),
    .s_axis_tready(s_tready1), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .m_len_tdata(len1), .m_len_tflags(flags1), .m_len_tvalid(lvalid1),
    .m_len_tready(len_tready1)
  );

  axis_frame_len_meter #(.DATA_WIDTH(64), .USER_WIDTH(1), .LEN_WIDTH(8)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid & en2),
    .s_axis_tready(s_tready2), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m2_tdata), .m_axis_tkeep(m2_tkeep), .m_axis_tvalid(m2_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m2_tlast), .m_axis_tuser(m2_tuser),
    .m_len_tdata(len2), .m_len_tflags(flags2), .m_len_tvalid(lvalid2),
    .m_len_tready(len_tready2)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
    logic [31:0] c;
  } beat_t;

  typedef struct packed {
    logic [15:0] len;
    logic [3:0]  flags;
  } st_t;

  beat_t data_q[$];
  st_t   st1_q[$];
  st_t   st2_q[$];

  // Backpressure generator on the data output.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard: data beats and status words, sampled on the falling edge.
  always @(negedge clk) begin
    beat_t b;
    st_t   e;
    if (!rst_n) begin
      data_q.delete();
    end else begin
      if (m_tvalid && m_tready) begin
        if (data_q.size() == 0) begin
          check_val("m_axis_unexpected", 64'd1, 64'd0);
        end else begin
          b = data_q.pop_front();
          check_val("tdata", m_tdata, b.d);
          check_val("tkeep", 64'(m_tkeep), 64'(b.k));
          check_val("tlast", 64'(m_tlast), 64'(b.l));
          check_val("tuser", 64'(m_tuser), 64'(b.u));
          if (lat_chk) check_val("latency", 64'(cyc), 64'(b.c + 32'd1));
        end
      end
      if (s_tvalid && en1 && s_tready1) begin
        b.d = s_tdata; b.k = s_tkeep; b.l = s_tlast; b.u = s_tuser[0]; b.c = cyc;
        data_q.push_back(b);
      end
      if (lvalid1 && len_tready1) begin
        if (st1_q.size() == 0) begin
          check_val("status_unexpected", 64'd1, 64'd0);
        end else begin
          e = st1_q.pop_front();
          $display("status len=%0d flags=%b (exp len=%0d flags=%b)", len1, flags1, e.len, e.flags);
          check_val("status_len", 64'(len1), 64'(e.len));
          check_val("status_flags", 64'(flags1), 64'(e.flags));
        end
      end
      if (lvalid2 && len_tready2) begin
        if (st2_q.size() == 0) begin
          check_val("status8_unexpected", 64'd1, 64'd0);
        end else begin
          e = st2_q.pop_front();
          $display("status8 len=%0d flags=%b (exp len=%0d flags=%b)", len2, flags2, e.len, e.flags);
          check_val("status8_len", 64'(len2), 64'(e.len));
          check_val("status8_flags", 64'(flags2), 64'(e.flags));
        end
      end
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    int  n;
    bit  hs;
    n = 0;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
    do begin
      @(negedge clk);
      hs = en2 ? s_tready2 : s_tready1;
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 500);
    if (!hs) check_val("send_timeout", 64'd0, 64'd1);
    s_tvalid = 1'b0;
  endtask

  // Sends a frame; beats are full except the last (last_k) and odd_b (odd_k).
  // abort_at >= 0 stops after that many beats and expects no status.
  task automatic send_frame(input int nb, input logic [7:0] last_k, input int err_b,
                            input int odd_b, input logic [7:0] odd_k,
                            input int abort_at, input int lw);
    logic [7:0] k;
    longint     tot, maxv, len;
    st_t        e;
    tot = 0;
    for (int i = 0; i < nb; i++) begin
      k = (i == nb - 1) ? last_k : ((i == odd_b) ? odd_k : 8'hFF);
      tot += $countones(k);
    end
    if (abort_at < 0) begin
      maxv = (64'd1 << lw) - 1;
      len = (tot > maxv) ? maxv : tot;
      e.len = 16'(len);
      e.flags = {tot > maxv, (err_b >= 0 && err_b < nb), len > 1518, len < 60};
      if (en2) st2_q.push_back(e); else st1_q.push_back(e);
    end
    for (int i = 0; i < nb; i++) begin
      if (i == abort_at) return;
      k = (i == nb - 1) ? last_k : ((i == odd_b) ? odd_k : 8'hFF);
      send_beat({$urandom, $urandom}, k, i == nb - 1, i == err_b);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((data_q.size() != 0 || st1_q.size() != 0 || st2_q.size() != 0 || m_tvalid) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    if (n >= 1000) check_val("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    check_val("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check_val("rst_len_tvalid", 64'(lvalid1), 64'd0);
    check_val("rst_m_tdata", m_tdata, 64'd0);
    check_val("rst_len", 64'(len1), 64'd0);
    check_val("rst_flags", 64'(flags1), 64'd0);
    check_val("rst_s_tready", 64'(s_tready1), 64'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check_val("ready_before_edge", 64'(s_tready1), 64'd0);
    @(posedge clk);
    #1 check_val("ready_after_release", 64'(s_tready1), 64'd1);

    // 64-byte frame, latency check
    lat_chk = 1'b1;
    send_frame(8, 8'hFF, -1, -1, 8'hFF, -1, 16);
    wait_drain();
    lat_chk = 1'b0;

    // Runt single beat, then a frame counting from zero
    send_frame(1, 8'h0F, -1, -1, 8'hFF, -1, 16);
    send_frame(8, 8'hFF, -1, -1, 8'hFF, -1, 16);
    wait_drain();

    // Oversize 1519 bytes
    send_frame(190, 8'h7F, -1, -1, 8'hFF, -1, 16);
    wait_drain();

    // Saturation on the 8-bit length instance: 300 bytes
    en1 = 1'b0; en2 = 1'b1;
    send_frame(38, 8'h0F, -1, -1, 8'hFF, -1, 8);
    wait_drain();
    en2 = 1'b0; en1 = 1'b1;

    // Error on beat 3, non-contiguous keep, random output backpressure
    bp_en = 1'b1;
    send_frame(8, 8'hFF, 2, 4, 8'hA5, -1, 16);
    send_frame(8, 8'hFF, -1, -1, 8'hFF, -1, 16);
    bp_en = 1'b0;
    wait_drain();

    // Status backpressure: second tlast beat stalls until the slot drains
    len_tready1 = 1'b0;
    fork
      begin
        send_frame(8, 8'hFF, -1, -1, 8'hFF, -1, 16);
        send_frame(8, 8'hFF, -1, -1, 8'hFF, -1, 16);
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!(s_tvalid && s_tlast && lvalid1) && n < 200);
        check_val("stall_seen", 64'(n < 200), 64'd1);
        check_val("stall_ready", 64'(s_tready1), 64'd0);
        repeat (3) @(negedge clk);
        check_val("stall_hold", 64'(s_tready1), 64'd0);
        check_val("stall_len_valid", 64'(lvalid1), 64'd1);
        check_val("stall_len_stable", 64'(len1), 64'd64);
        @(posedge clk); #1 len_tready1 = 1'b1;
        @(posedge clk); #1 len_tready1 = 1'b0;
        check_val("replaced_valid", 64'(lvalid1), 64'd1);
        repeat (3) @(posedge clk);
        #1 len_tready1 = 1'b1;
      end
    join
    wait_drain();

    // Reset mid-frame after 4 beats
    send_frame(8, 8'hFF, -1, -1, 8'hFF, 4, 16);
    check_val("pre_rst_m_tvalid", 64'(m_tvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check_val("async_rst_len_tvalid", 64'(lvalid1), 64'd0);
    check_val("async_rst_s_tready", 64'(s_tready1), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    send_frame(8, 8'hFF, -1, -1, 8'hFF, -1, 16);
    wait_drain();

    check_val("st1_q_empty", 64'(st1_q.size()), 64'd0);
    check_val("st2_q_empty", 64'(st2_q.size()), 64'd0);
    check_val("data_q_empty", 64'(data_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
